ms_mpu_unit: RTL and testbench

- Parametrised, registered successor to the per-core combinational MPU.
- Sits between one core's data/code request port and the memory/peripheral decoder.
- Holds CRegionCnt relocation regions. Each region carries R/W/X permissions, and a fixed priority resolves overlaps.
- Translation result goes into a one-deep output stage with valid/ready backpressure.
- Faults are captured in sticky registers with an overflow counter.

---
 rtl/ms_mpu_pkg.sv | 47 ++++
 rtl/ms_mpu_region.sv | 36 +++
 rtl/ms_mpu_unit.sv | 185 ++++++++++++++++++
 tb/tb_ms_mpu_unit.sv | 333 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/ms_mpu_pkg.sv
// ms_mpu_pkg: shared encodings and region word layout for the ms_mpu_unit MPU.
//   kind encodings  : access kind carried on AReqKind / AMemKind / AFaultKind
//   cause encodings : fault cause reported on AFaultCause
//   region_t        : 64-bit region word, field order fixes the bit positions
//   shift constants : address granularity shifts (4 KiB / 16 B)
package ms_mpu_pkg;

  localparam int unsigned ADDR_W    = 32;
  localparam int unsigned WORD_W    = 64;
  localparam int unsigned FIELD_W   = 20;
  localparam int unsigned SHIFT_4K  = 12;
  localparam int unsigned SHIFT_16B = 4;

  localparam logic [1:0] KIND_NONE  = 2'd0;
  localparam logic [1:0] KIND_READ  = 2'd1;
  localparam logic [1:0] KIND_WRITE = 2'd2;
  localparam logic [1:0] KIND_EXEC  = 2'd3;

  localparam logic [1:0] CAUSE_NONE = 2'd0;
  localparam logic [1:0] CAUSE_MISS = 2'd1;
  localparam logic [1:0] CAUSE_PERM = 2'd2;

  // Bit positions: gran[63] x[62] w[61] r[60] base[59:40] lim[39:20] start[19:0]
  typedef struct packed {
    logic               gran;
    logic               x;
    logic               w;
    logic               r;
    logic [FIELD_W-1:0] base;
    logic [FIELD_W-1:0] lim;
    logic [FIELD_W-1:0] start;
  } region_t;

  // Permission bit that the given access kind requires
  function automatic logic perm_for_kind(input region_t rgn, input logic [1:0] kind);
    logic ok;
    ok = 1'b0;
    case (kind)
      KIND_READ:  ok = rgn.r;
      KIND_WRITE: ok = rgn.w;
      KIND_EXEC:  ok = rgn.x;
      default:    ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/ms_mpu_region.sv
// ms_mpu_region: combinational compare of one address against one region word.
//   i_region  : 64-bit region word (ms_mpu_pkg::region_t layout)
//   i_addr    : CPU virtual address
//   i_kind    : access kind
//   o_in_use  : region is configured (lim != 0)
//   o_hit     : region in use and start <= compare value < lim
//   o_perm_ok : region grants the permission required by i_kind
//   o_offset  : relocation offset to add to the address
module ms_mpu_region
  import ms_mpu_pkg::*;
(
  input  logic [WORD_W-1:0] i_region,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [1:0]        i_kind,
  output logic              o_in_use,
  output logic              o_hit,
  output logic              o_perm_ok,
  output logic [ADDR_W-1:0] o_offset
);

  region_t            w_rgn;
  logic [FIELD_W-1:0] w_cmp;

  assign w_rgn = region_t'(i_region);

  // Compare value: page number for 4 KiB granularity, 16 B block index otherwise
  assign w_cmp = w_rgn.gran ? FIELD_W'(i_addr >> SHIFT_4K)
                            : FIELD_W'(i_addr >> SHIFT_16B);

  assign o_in_use  = |w_rgn.lim;
  assign o_hit     = o_in_use && (w_cmp >= w_rgn.start) && (w_cmp < w_rgn.lim);
  assign o_perm_ok = perm_for_kind(w_rgn, i_kind);
  assign o_offset  = w_rgn.gran ? (ADDR_W'(w_rgn.base) << SHIFT_4K)
                                : (ADDR_W'(w_rgn.base) << SHIFT_16B);

endmodule

// File: rtl/ms_mpu_unit.sv
// ms_mpu_unit: registered relocating MPU between a core request port and the
// memory/peripheral decoder.
//   AClkH/AResetH/AClkHEn          : clock, async active-high reset, clock enable
//   ACfgWrEn/ACfgWrIdx/ACfgMosi    : region word write port
//   ACfgRdIdx/ACfgMiso             : combinational region word read-back
//   AReqAddr/AReqKind/AReqValid/AReqReady : request side
//   AMemAddr/AMemKind/AMemValid/AMemReady : one-deep translated output stage
//   AReqErr                        : pulse, previous accepted request faulted
//   AFault/AFaultAddr/AFaultKind/AFaultCause/AFaultOvf/AFaultClr : sticky fault capture
module ms_mpu_unit
  import ms_mpu_pkg::*;
#(
  parameter int unsigned CRegionCnt = 4,
  parameter int unsigned CIdxBits   = 4
) (
  input  logic                AClkH,
  input  logic                AResetH,
  input  logic                AClkHEn,
  input  logic                ACfgWrEn,
  input  logic [CIdxBits-1:0] ACfgWrIdx,
  input  logic [WORD_W-1:0]   ACfgMosi,
  input  logic [CIdxBits-1:0] ACfgRdIdx,
  output logic [WORD_W-1:0]   ACfgMiso,
  input  logic [ADDR_W-1:0]   AReqAddr,
  input  logic [1:0]          AReqKind,
  input  logic                AReqValid,
  output logic                AReqReady,
  output logic [ADDR_W-1:0]   AMemAddr,
  output logic [1:0]          AMemKind,
  output logic                AMemValid,
  input  logic                AMemReady,
  output logic                AReqErr,
  output logic                AFault,
  output logic [ADDR_W-1:0]   AFaultAddr,
  output logic [1:0]          AFaultKind,
  output logic [1:0]          AFaultCause,
  output logic [7:0]          AFaultOvf,
  input  logic                AFaultClr
);

  logic [WORD_W-1:0] r_region [CRegionCnt];

  logic              r_mem_valid;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [1:0]        r_mem_kind;
  logic              r_req_err;
  logic              r_fault;
  logic [ADDR_W-1:0] r_fault_addr;
  logic [1:0]        r_fault_kind;
  logic [1:0]        r_fault_cause;
  logic [7:0]        r_fault_ovf;

  logic [CRegionCnt-1:0] w_use;
  logic [CRegionCnt-1:0] w_hit;
  logic [CRegionCnt-1:0] w_perm;
  logic [ADDR_W-1:0]     w_off [CRegionCnt];

  logic              w_any_use;
  logic              w_any_hit;
  logic              w_win_perm;
  logic [ADDR_W-1:0] w_win_off;
  logic              w_fault;
  logic [1:0]        w_cause;
  logic [ADDR_W-1:0] w_xaddr;
  logic              w_ready;
  logic              w_accept;
  logic              w_drain;
  logic [WORD_W-1:0] w_miso;

  // Per-region compare
  for (genvar g = 0; g < CRegionCnt; g++) begin : g_rgn
    ms_mpu_region u_rgn (
      .i_region  (r_region[g]),
      .i_addr    (AReqAddr),
      .i_kind    (AReqKind),
      .o_in_use  (w_use[g]),
      .o_hit     (w_hit[g]),
      .o_perm_ok (w_perm[g]),
      .o_offset  (w_off[g])
    );
  end

  // Priority encoder: scanning downwards lets the lowest hitting index win
  always_comb begin
    w_any_use  = 1'b0;
    w_any_hit  = 1'b0;
    w_win_perm = 1'b0;
    w_win_off  = '0;
    for (int i = int'(CRegionCnt) - 1; i >= 0; i--) begin
      w_any_use = w_any_use | w_use[i];
      if (w_hit[i]) begin
        w_any_hit  = 1'b1;
        w_win_perm = w_perm[i];
        w_win_off  = w_off[i];
      end
    end
  end

  // Bypass (no region in use) never faults and adds a zero offset
  assign w_fault = w_any_use && (!w_any_hit || !w_win_perm);
  assign w_cause = w_any_hit ? CAUSE_PERM : CAUSE_MISS;
  assign w_xaddr = AReqAddr + w_win_off;

  assign w_ready  = !r_mem_valid || AMemReady;
  assign w_accept = AReqValid && w_ready && (AReqKind != KIND_NONE) && AClkHEn;
  assign w_drain  = r_mem_valid && AMemReady;

  // Combinational read-back; out-of-range indices read as zero
  always_comb begin
    w_miso = '0;
    for (int i = 0; i < int'(CRegionCnt); i++) begin
      if (ACfgRdIdx == CIdxBits'(i)) w_miso = r_region[i];
    end
  end

  // Region configuration; out-of-range write indices match nothing
  always_ff @(posedge AClkH or posedge AResetH) begin
    if (AResetH) begin
      for (int i = 0; i < int'(CRegionCnt); i++) r_region[i] <= '0;
    end else if (AClkHEn && ACfgWrEn) begin
      for (int i = 0; i < int'(CRegionCnt); i++) begin
        if (ACfgWrIdx == CIdxBits'(i)) r_region[i] <= ACfgMosi;
      end
    end
  end

  // Output stage and error pulse
  always_ff @(posedge AClkH or posedge AResetH) begin
    if (AResetH) begin
      r_mem_valid <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_kind  <= KIND_NONE;
      r_req_err   <= 1'b0;
    end else if (AClkHEn) begin
      r_req_err <= w_accept && w_fault;
      if (w_accept && !w_fault) begin
        r_mem_valid <= 1'b1;
        r_mem_addr  <= w_xaddr;
        r_mem_kind  <= AReqKind;
      end else if (w_drain) begin
        r_mem_valid <= 1'b0;
      end
    end
  end

  // Sticky fault capture; a clear in the same cycle as a fault re-arms first capture
  always_ff @(posedge AClkH or posedge AResetH) begin
    if (AResetH) begin
      r_fault       <= 1'b0;
      r_fault_addr  <= '0;
      r_fault_kind  <= KIND_NONE;
      r_fault_cause <= CAUSE_NONE;
      r_fault_ovf   <= '0;
    end else if (AClkHEn) begin
      if (w_accept && w_fault && (!r_fault || AFaultClr)) begin
        r_fault       <= 1'b1;
        r_fault_addr  <= AReqAddr;
        r_fault_kind  <= AReqKind;
        r_fault_cause <= w_cause;
        r_fault_ovf   <= '0;
      end else if (AFaultClr) begin
        r_fault       <= 1'b0;
        r_fault_addr  <= '0;
        r_fault_kind  <= KIND_NONE;
        r_fault_cause <= CAUSE_NONE;
        r_fault_ovf   <= '0;
      end else if (w_accept && w_fault && (r_fault_ovf != 8'hFF)) begin
        r_fault_ovf <= r_fault_ovf + 8'd1;
      end
    end
  end

  assign ACfgMiso    = w_miso;
  assign AReqReady   = w_ready;
  assign AMemValid   = r_mem_valid;
  assign AMemAddr    = r_mem_addr;
  assign AMemKind    = r_mem_kind;
  assign AReqErr     = r_req_err;
  assign AFault      = r_fault;
  assign AFaultAddr  = r_fault_addr;
  assign AFaultKind  = r_fault_kind;
  assign AFaultCause = r_fault_cause;
  assign AFaultOvf   = r_fault_ovf;

endmodule

// File: tb/tb_ms_mpu_unit.sv
// tb_ms_mpu_unit: directed plus randomized bench for ms_mpu_unit with a
// reference model and a scoreboard of expected translated transfers.
module tb_ms_mpu_unit;

  localparam int unsigned N  = 4;
  localparam int unsigned IW = 4;

  logic          clk;
  logic          rst;
  logic          en;
  logic          cfg_wr;
  logic [IW-1:0] cfg_widx;
  logic [63:0]   cfg_mosi;
  logic [IW-1:0] cfg_ridx;
  logic [63:0]   cfg_miso;
  logic [31:0]   req_addr;
  logic [1:0]    req_kind;
  logic          req_valid;
  logic          req_ready;
  logic [31:0]   mem_addr;
  logic [1:0]    mem_kind;
  logic          mem_valid;
  logic          mem_ready;
  logic          req_err;
  logic          flt;
  logic [31:0]   flt_addr;
  logic [1:0]    flt_kind;
  logic [1:0]    flt_cause;
  logic [7:0]    flt_ovf;
  logic          flt_clr;

  ms_mpu_unit #(.CRegionCnt(N), .CIdxBits(IW)) dut (
    .AClkH(clk), .AResetH(rst), .AClkHEn(en),
    .ACfgWrEn(cfg_wr), .ACfgWrIdx(cfg_widx), .ACfgMosi(cfg_mosi),
    .ACfgRdIdx(cfg_ridx), .ACfgMiso(cfg_miso),
    .AReqAddr(req_addr), .AReqKind(req_kind), .AReqValid(req_valid), .AReqReady(req_ready),
    .AMemAddr(mem_addr), .AMemKind(mem_kind), .AMemValid(mem_valid), .AMemReady(mem_ready),
    .AReqErr(req_err), .AFault(flt), .AFaultAddr(flt_addr), .AFaultKind(flt_kind),
    .AFaultCause(flt_cause), .AFaultOvf(flt_ovf), .AFaultClr(flt_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  typedef struct {
    logic [31:0] a;
    logic [1:0]  k;
  } exp_t;

  exp_t        sb[$];
  logic [63:0] m_rgn [N];
  logic        m_valid;
  logic        m_err;
  logic        m_fault;
  logic [31:0] m_faddr;
  logic [1:0]  m_fkind;
  logic [1:0]  m_fcause;
  int          m_ovf;

  // Translation from the region rules, using plain integer arithmetic
  function automatic void ref_xlate(input logic [31:0] a, input logic [1:0] k,
                                    output bit fault, output logic [1:0] cause,
                                    output logic [31:0] xa);
    longint unsigned av, v, s, e, b, off;
    bit used;
    bit ok;
    logic [63:0] w;
    av = a;
    used = 0;
    fault = 0;
    cause = 2'd0;
    xa = a;
    for (int i = 0; i < N; i++) if (m_rgn[i][39:20] != 0) used = 1;
    if (!used) return;
    for (int i = 0; i < N; i++) begin
      w = m_rgn[i];
      s = w[19:0];
      e = w[39:20];
      b = w[59:40];
      v = w[63] ? av / 4096 : (av / 16) % (64'd1 << 20);
      if (e != 0 && v >= s && v < e) begin
        ok = (k == 2'd1) ? w[60] : (k == 2'd2) ? w[61] : w[62];
        if (!ok) begin
          fault = 1;
          cause = 2'd2;
          return;
        end
        off = w[63] ? b * 4096 : b * 16;
        xa = 32'((av + off) % (64'd1 << 32));
        return;
      end
    end
    fault = 1;
    cause = 2'd1;
  endfunction

  // Compare visible state, then advance the model across the coming edge
  always @(negedge clk) begin
    bit acc, f, nv, ne;
    logic [1:0] c;
    logic [31:0] xa;
    logic [63:0] miso_exp;
    int ri, wi;
    if (rst) begin
      for (int i = 0; i < N; i++) m_rgn[i] = '0;
      m_valid = 0; m_err = 0; m_fault = 0; m_faddr = '0;
      m_fkind = '0; m_fcause = '0; m_ovf = 0;
      sb.delete();
    end else begin
      ri = int'(cfg_ridx);
      miso_exp = (ri < N) ? m_rgn[ri] : 64'd0;
      chk("mem_valid", mem_valid, m_valid);
      chk("req_ready", req_ready, !m_valid || mem_ready);
      chk("req_err", req_err, m_err);
      chk("fault", flt, m_fault);
      chk("fault_addr", flt_addr, m_faddr);
      chk("fault_kind", flt_kind, m_fkind);
      chk("fault_cause", flt_cause, m_fcause);
      chk("fault_ovf", flt_ovf, 64'(m_ovf));
      chk("cfg_miso", cfg_miso, miso_exp);
      if (en) begin
        acc = req_valid && (!m_valid || mem_ready) && (req_kind != 2'd0);
        nv = m_valid && !mem_ready;
        ne = 0;
        f = 0;
        if (acc) begin
          ref_xlate(req_addr, req_kind, f, c, xa);
          if (!f) begin
            sb.push_back('{a: xa, k: req_kind});
            nv = 1;
          end else begin
            ne = 1;
          end
        end
        if (flt_clr) begin
          m_fault = 0; m_faddr = '0; m_fkind = '0; m_fcause = '0; m_ovf = 0;
        end
        if (acc && f) begin
          if (!m_fault) begin
            m_fault = 1; m_faddr = req_addr; m_fkind = req_kind; m_fcause = c; m_ovf = 0;
          end else if (m_ovf < 255) begin
            m_ovf++;
          end
        end
        wi = int'(cfg_widx);
        if (cfg_wr && wi < N) m_rgn[wi] = cfg_mosi;
        m_valid = nv;
        m_err = ne;
      end
    end
  end

  // Monitor: every transfer out of the output stage must match the oldest expectation
  always @(negedge clk) begin
    exp_t e;
    if (!rst && mem_valid && mem_ready && en) begin
      if (sb.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL sb_unexpected: got addr %h with no expected transfer", mem_addr);
      end else begin
        e = sb.pop_front();
        chk("sb_addr", mem_addr, e.a);
        chk("sb_kind", mem_kind, e.k);
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    req_valid = 0;
    cfg_wr = 0;
    flt_clr = 0;
  endtask

  task automatic req(input logic [31:0] a, input logic [1:0] k);
    req_valid = 1;
    req_addr = a;
    req_kind = k;
  endtask

  task automatic cfg(input logic [IW-1:0] idx, input logic [63:0] w);
    cfg_wr = 1;
    cfg_widx = idx;
    cfg_mosi = w;
    cyc();
    cfg_wr = 0;
  endtask

  function automatic logic [63:0] rnd_region();
    logic        g;
    logic [2:0]  p;
    logic [19:0] b, s, l;
    if ($urandom % 8 == 0) return 64'd0;
    g = 1'($urandom % 2);
    p = 3'($urandom % 8);
    b = 20'($urandom);
    if (g) begin
      s = 20'($urandom_range(0, 9));
      l = s + 20'($urandom_range(0, 4));
    end else begin
      s = 20'($urandom_range(0, 'h9FF));
      l = s + 20'($urandom_range(0, 'h200));
    end
    return {g, p, b, l, s};
  endfunction

  function automatic logic [31:0] rnd_addr();
    if ($urandom % 4 == 0) return 32'($urandom);
    return 32'($urandom_range(0, 'h9FFF));
  endfunction

  initial begin
    rst = 1; en = 1; cfg_wr = 0; cfg_widx = '0; cfg_mosi = '0; cfg_ridx = '0;
    req_addr = '0; req_kind = '0; req_valid = 0; mem_ready = 1; flt_clr = 0;
    repeat (2) cyc();
    rst = 0;
    cyc();
    chk("rst_valid", mem_valid, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_fault", flt, 0);
    chk("rst_ovf", flt_ovf, 0);
    chk("rst_miso", cfg_miso, 0);

    // bypass with no region in use
    req(32'h0001_2345, 2'd1); cyc(); idle();
    chk("bypass_valid", mem_valid, 1);
    chk("bypass_addr", mem_addr, 32'h0001_2345);
    chk("bypass_err", req_err, 0);

    // 16 B granularity relocation
    cfg(0, 64'h1_00400_00200_00100);
    req(32'h0000_1010, 2'd1); cyc(); idle();
    chk("small_gran_addr", mem_addr, 32'h0000_5010);

    // overlapping 4 KiB regions, lowest index wins
    cfg(0, 64'h9_00001_00010_00000);
    cfg(1, 64'h9_00002_00010_00000);
    req(32'h0000_3000, 2'd1); cyc(); idle();
    chk("priority_addr", mem_addr, 32'h0000_4000);

    // permission fault, then two misses counted as overflow
    req(32'h0000_1000, 2'd2); cyc(); idle();
    chk("perm_err", req_err, 1);
    chk("perm_valid", mem_valid, 0);
    chk("perm_fault", flt, 1);
    chk("perm_cause", flt_cause, 2);
    chk("perm_kind", flt_kind, 2);
    chk("perm_addr", flt_addr, 32'h0000_1000);
    req(32'h0002_0000, 2'd1); cyc();
    req(32'h0004_0000, 2'd3); cyc(); idle();
    chk("ovf_two", flt_ovf, 2);
    chk("ovf_first_addr", flt_addr, 32'h0000_1000);

    // backpressure, then drain and accept in the same cycle
    mem_ready = 0;
    req(32'h0000_3000, 2'd1); cyc();
    req(32'h0000_3004, 2'd1);
    for (int i = 0; i < 3; i++) begin
      chk("bp_ready", req_ready, 0);
      chk("bp_addr", mem_addr, 32'h0000_4000);
      cyc();
    end
    mem_ready = 1;
    #1 chk("bp_release_ready", req_ready, 1);
    cyc(); idle();
    chk("bp_new_valid", mem_valid, 1);
    chk("bp_new_addr", mem_addr, 32'h0000_4004);

    // clear and miss together re-capture as first fault
    flt_clr = 1;
    req(32'h0003_0000, 2'd1); cyc(); idle();
    chk("clr_fault", flt, 1);
    chk("clr_ovf", flt_ovf, 0);
    chk("clr_addr", flt_addr, 32'h0003_0000);
    chk("clr_cause", flt_cause, 1);

    // asynchronous reset with a transfer stalled in the output stage
    mem_ready = 0;
    req(32'h0000_3000, 2'd1); cyc(); idle();
    chk("pre_rst_valid", mem_valid, 1);
    rst = 1;
    #1;
    chk("async_rst_valid", mem_valid, 0);
    chk("async_rst_fault", flt, 0);
    cyc();
    rst = 0;
    mem_ready = 1;
    cyc();

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      en        = ($urandom % 10) != 0;
      mem_ready = ($urandom % 4) != 0;
      req_valid = ($urandom % 3) != 0;
      req_kind  = 2'($urandom % 4);
      req_addr  = rnd_addr();
      cfg_wr    = ($urandom % 16) == 0;
      cfg_widx  = IW'($urandom % 16);
      cfg_mosi  = rnd_region();
      cfg_ridx  = IW'($urandom % 16);
      flt_clr   = ($urandom % 20) == 0;
      cyc();
    end

    idle();
    en = 1;
    mem_ready = 1;
    repeat (4) cyc();
    chk("sb_drained", 64'(sb.size()), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
